// File: rtl/ro_sensor_hub_pkg.sv
// Shared opcodes, frame constants and FSM state encoding for ro_sensor_hub.
// RO_SENSOR_CHECKSUM_EN adds the checksum state to the encoding.
package ro_sensor_pkg;

  localparam logic [7:0] CMD_CH_BASE = 8'h30;
  localparam logic [7:0] CMD_ALL     = 8'h41;
  localparam logic [7:0] FRAME_HDR   = 8'hA5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_ACCUM,
    ST_SEND_HDR,
    ST_SEND_ID,
    ST_SEND_DATA,
`ifdef RO_SENSOR_CHECKSUM_EN
    ST_SEND_CSUM,
`endif
    ST_TX_WAIT,
    ST_NEXT
  } state_e;

  function automatic int result_bytes(input int cnt_w);
    return (cnt_w + 7) / 8;
  endfunction

endpackage

// File: rtl/ro_sensor_hub_if.sv
// UART-side command/transmit bundle; master is the hub, slave is the UART.
interface ro_sensor_hub_if;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (input rx_ready, rx_data, tx_busy, output tx_start, tx_data);
  modport slave  (output rx_ready, rx_data, tx_busy, input tx_start, tx_data);
endinterface

// File: rtl/ro_gate_counter.sv
// Synchronises one oscillator, detects rising edges and counts them while
// gated, saturating at all-ones.
module ro_gate_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ro,
  input  logic             i_clr,
  input  logic             i_gate,
  output logic [CNT_W-1:0] o_cnt
);

  // [0],[1] synchroniser stages, [2] previous value for edge detection
  logic [2:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;

  assign w_rise = r_sync[1] & ~r_sync[2];
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_ro};
      if (i_clr)
        r_cnt <= '0;
      else if (i_gate && w_rise && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ro_sensor_hub.sv
// Ring-oscillator readout: measures one or all channels on a UART command and
// streams averaged counts as frames. RO_SENSOR_CHECKSUM_EN appends an XOR byte.
module ro_sensor_hub
  import ro_sensor_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   ro_in,
  output logic [N_CH-1:0]   ro_en,
  output logic              busy,
  ro_sensor_hub_if.master   uart
);

  localparam int ACC_W   = CNT_W + AVG_LOG2;
  localparam int NBYTES  = result_bytes(CNT_W);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int WIN_W   = AVG_LOG2 + 1;
  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  state_e             r_state, r_ret, w_next, w_ret;
  logic [CH_W-1:0]    r_ch, w_cmd_ch;
  logic               r_all, r_busy, r_tx_start, r_wait_first;
  logic [TMR_W-1:0]   r_tmr;
  logic [WIN_W-1:0]   r_win;
  logic [ACC_W-1:0]   r_acc;
  logic [1:0]         r_bidx;
  logic [7:0]         r_tx_data, r_csum;
  logic [7:0]         w_cmd_off, w_byte, w_res_byte;
  logic               w_cmd_is_ch, w_cmd_all, w_cmd_ok, w_issue, w_meas, w_clr;
  logic [CNT_W-1:0]   w_cnt, w_result;

  assign w_cmd_off   = uart.rx_data - CMD_CH_BASE;
  assign w_cmd_is_ch = (uart.rx_data >= CMD_CH_BASE) && (w_cmd_off < 8'(N_CH));
  assign w_cmd_all   = (uart.rx_data == CMD_ALL);
  assign w_cmd_ok    = w_cmd_is_ch || w_cmd_all;
  assign w_cmd_ch    = CH_W'(w_cmd_off);

  assign w_result   = CNT_W'(r_acc >> AVG_LOG2);
  assign w_res_byte = 8'(w_result >> {r_bidx, 3'b000});

  assign w_meas = (r_state == ST_SETTLE) || (r_state == ST_GATE) || (r_state == ST_ACCUM);
  assign w_clr  = (w_next == ST_GATE) && (r_state != ST_GATE);

  assign ro_en         = w_meas ? (N_CH'(1) << r_ch) : '0;
  assign busy          = r_busy;
  assign uart.tx_start = r_tx_start;
  assign uart.tx_data  = r_tx_data;

  ro_gate_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_ro   (ro_in[r_ch]),
    .i_clr  (w_clr),
    .i_gate (r_state == ST_GATE),
    .o_cnt  (w_cnt)
  );

  always_comb begin
    w_next  = r_state;
    w_ret   = r_ret;
    w_issue = 1'b0;
    w_byte  = 8'h00;
    case (r_state)
      ST_IDLE:   if (uart.rx_ready && w_cmd_ok) w_next = ST_SETTLE;
      ST_SETTLE: if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) w_next = ST_GATE;
      ST_GATE:   if (r_tmr == TMR_W'(GATE_CYCLES - 1)) w_next = ST_ACCUM;
      ST_ACCUM:  w_next = (r_win == WIN_W'((1 << AVG_LOG2) - 1)) ? ST_SEND_HDR : ST_GATE;
      ST_SEND_HDR: begin
        w_byte = FRAME_HDR;
        w_ret  = ST_SEND_ID;
      end
      ST_SEND_ID: begin
        w_byte = 8'(r_ch);
        w_ret  = ST_SEND_DATA;
      end
      ST_SEND_DATA: begin
        w_byte = w_res_byte;
`ifdef RO_SENSOR_CHECKSUM_EN
        w_ret  = (r_bidx == 2'(NBYTES - 1)) ? ST_SEND_CSUM : ST_SEND_DATA;
`else
        w_ret  = (r_bidx == 2'(NBYTES - 1)) ? ST_NEXT : ST_SEND_DATA;
`endif
      end
`ifdef RO_SENSOR_CHECKSUM_EN
      ST_SEND_CSUM: begin
        w_byte = r_csum;
        w_ret  = ST_NEXT;
      end
`endif
      // first cycle after tx_start gives the UART time to raise tx_busy
      ST_TX_WAIT: if (!r_wait_first && !uart.tx_busy) w_next = r_ret;
      ST_NEXT:    w_next = (r_all && (r_ch != CH_W'(N_CH - 1))) ? ST_SETTLE : ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    if ((r_state == ST_SEND_HDR) || (r_state == ST_SEND_ID) ||
`ifdef RO_SENSOR_CHECKSUM_EN
        (r_state == ST_SEND_CSUM) ||
`endif
        (r_state == ST_SEND_DATA)) begin
      if (!uart.tx_busy) begin
        w_issue = 1'b1;
        w_next  = ST_TX_WAIT;
      end else begin
        w_ret = r_ret;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ret        <= ST_IDLE;
      r_ch         <= '0;
      r_all        <= 1'b0;
      r_busy       <= 1'b0;
      r_tmr        <= '0;
      r_win        <= '0;
      r_acc        <= '0;
      r_bidx       <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_wait_first <= 1'b0;
      r_csum       <= '0;
    end else begin
      r_state      <= w_next;
      r_ret        <= w_ret;
      r_busy       <= (w_next != ST_IDLE);
      r_tmr        <= (w_next != r_state) ? '0 : r_tmr + 1'b1;
      r_tx_start   <= w_issue;
      r_wait_first <= w_issue;
      if ((r_state == ST_IDLE) && (w_next == ST_SETTLE)) begin
        r_all <= w_cmd_all;
        r_ch  <= w_cmd_all ? '0 : w_cmd_ch;
      end else if ((r_state == ST_NEXT) && (w_next == ST_SETTLE)) begin
        r_ch <= r_ch + 1'b1;
      end
      if ((w_next == ST_SETTLE) && (r_state != ST_SETTLE)) begin
        r_acc <= '0;
        r_win <= '0;
      end else if (r_state == ST_ACCUM) begin
        r_acc <= r_acc + ACC_W'(w_cnt);
        r_win <= r_win + 1'b1;
      end
      if (w_issue) begin
        r_tx_data <= w_byte;
        r_csum    <= (r_state == ST_SEND_HDR) ? w_byte : (r_csum ^ w_byte);
        if (r_state == ST_SEND_ID)
          r_bidx <= '0;
        else if (r_state == ST_SEND_DATA)
          r_bidx <= r_bidx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ro_sensor_hub.sv
// Scoreboard bench for ro_sensor_hub: a 16-bit/100-cycle instance and an
// 8-bit/1000-cycle instance, each with a simple UART busy model.
module tb_ro_sensor_hub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] ro16 = '0;
  logic [3:0] ro8  = '0;
  logic [3:0] en16, en8;
  logic       busy16, busy8;
  logic       hold16 = 1'b0;
  int         bcnt16 = 0, bcnt8 = 0;
  int         per [4] = '{0, 0, 0, 0};
  int         cyc = 0;
  int         n_checks = 0, n_fail = 0;
  int         txcnt16 = 0, txcnt8 = 0;
  logic [7:0] q16 [$];
  logic [7:0] q8  [$];

  ro_sensor_hub_if if16 ();
  ro_sensor_hub_if if8 ();

  ro_sensor_hub #(.N_CH(4), .CNT_W(16), .GATE_CYCLES(100), .AVG_LOG2(2), .SETTLE_CYCLES(4)) u_dut16 (
    .clk(clk), .reset(rst), .ro_in(ro16), .ro_en(en16), .busy(busy16), .uart(if16)
  );

  ro_sensor_hub #(.N_CH(4), .CNT_W(8), .GATE_CYCLES(1000), .AVG_LOG2(2), .SETTLE_CYCLES(4)) u_dut8 (
    .clk(clk), .reset(rst), .ro_in(ro8), .ro_en(en8), .busy(busy8), .uart(if8)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART models: busy for 3 cycles after each tx_start
  assign if16.tx_busy = (bcnt16 != 0) || hold16;
  assign if8.tx_busy  = (bcnt8 != 0);
  always @(posedge clk) begin
    if (if16.tx_start) bcnt16 <= 3; else if (bcnt16 != 0) bcnt16 <= bcnt16 - 1;
    if (if8.tx_start)  bcnt8  <= 3; else if (bcnt8 != 0)  bcnt8  <= bcnt8 - 1;
    cyc <= cyc + 1;
  end

  // oscillator stimulus, 50% duty, period per[k] clocks (0 = stopped)
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      ro16[k] = (per[k] != 0) && ((cyc % per[k]) < per[k] / 2);
    ro8[0] = ~ro8[0];
  end

  always @(negedge clk) begin
    if (if16.tx_start) begin
      txcnt16++;
      check_eq("txbusy16", 32'(if16.tx_busy), 0);
      check_eq("expect16", 32'(q16.size() != 0), 1);
      if (q16.size() != 0) check_eq("byte16", 32'(if16.tx_data), 32'(q16.pop_front()));
    end
    if (if8.tx_start) begin
      txcnt8++;
      check_eq("txbusy8", 32'(if8.tx_busy), 0);
      check_eq("expect8", 32'(q8.size() != 0), 1);
      if (q8.size() != 0) check_eq("byte8", 32'(if8.tx_data), 32'(q8.pop_front()));
    end
  end

  task automatic push16(input logic [7:0] ch, input logic [15:0] res);
    logic [7:0] cs;
    q16.push_back(8'hA5); q16.push_back(ch); q16.push_back(res[7:0]); q16.push_back(res[15:8]);
    cs = 8'hA5 ^ ch ^ res[7:0] ^ res[15:8];
`ifdef RO_SENSOR_CHECKSUM_EN
    q16.push_back(cs);
`endif
  endtask

  task automatic cmd16(input logic [7:0] b);
    @(negedge clk); if16.rx_ready = 1'b1; if16.rx_data = b;
    @(negedge clk); if16.rx_ready = 1'b0;
  endtask

  task automatic wait_idle16(input string tag, input int budget);
    int n = 0;
    while (busy16 && n < budget) begin @(negedge clk); n++; end
    check_eq(tag, 32'(busy16), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    check_eq("rst_roen", 32'(en16), 0);
    check_eq("rst_txstart", 32'(if16.tx_start), 0);
    check_eq("rst_txdata", 32'(if16.tx_data), 0);
    check_eq("rst_busy", 32'(busy16), 0);
    rst = 1'b0;
    q16.delete();
  endtask

  initial begin
    int n;
    int tx_before;
    if16.rx_ready = 1'b0; if16.rx_data = 8'h00;
    if8.rx_ready  = 1'b0; if8.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("init_roen", 32'(en16), 0);
    check_eq("init_txstart", 32'(if16.tx_start), 0);
    check_eq("init_txdata", 32'(if16.tx_data), 0);
    check_eq("init_busy", 32'(busy16), 0);
    check_eq("init_busy8", 32'(busy8), 0);
    rst = 1'b0;

    // single channel 1, period 10
    per = '{0, 10, 0, 0};
    push16(8'h01, 16'h000A);
    cmd16(8'h31);
    check_eq("s1_busy", 32'(busy16), 1);
    repeat (30) @(negedge clk);
    check_eq("s1_roen", 32'(en16), 32'h2);
    wait_idle16("s1_idle", 2000);
    check_eq("s1_drain", 32'(q16.size()), 0);
    check_eq("s1_roen_off", 32'(en16), 0);

    // all channels, periods 10/20/30/40
    per = '{10, 20, 30, 40};
    push16(8'h00, 16'h000A); push16(8'h01, 16'h0005);
    push16(8'h02, 16'h0003); push16(8'h03, 16'h0002);
    cmd16(8'h41);
    wait_idle16("s2_idle", 3000);
    check_eq("s2_drain", 32'(q16.size()), 0);

    // saturation on the 8-bit instance
    q8.push_back(8'hA5); q8.push_back(8'h00); q8.push_back(8'hFF);
`ifdef RO_SENSOR_CHECKSUM_EN
    q8.push_back(8'hA5 ^ 8'h00 ^ 8'hFF);
`endif
    @(negedge clk); if8.rx_ready = 1'b1; if8.rx_data = 8'h30;
    @(negedge clk); if8.rx_ready = 1'b0;
    check_eq("s3_busy", 32'(busy8), 1);
    n = 0;
    while (busy8 && n < 6000) begin @(negedge clk); n++; end
    check_eq("s3_idle", 32'(busy8), 0);
    check_eq("s3_drain", 32'(q8.size()), 0);

    // ignored and dropped commands
    per = '{0, 10, 0, 0};
    cmd16(8'h38);
    repeat (3) @(negedge clk);
    check_eq("s4_bad38", 32'(busy16), 0);
    cmd16(8'h5A);
    repeat (3) @(negedge clk);
    check_eq("s4_bad5A", 32'(busy16), 0);
    tx_before = txcnt16;
    push16(8'h01, 16'h000A);
    cmd16(8'h31);
    repeat (50) @(negedge clk);
    cmd16(8'h33);
    repeat (5) @(negedge clk);
    check_eq("s4_roen", 32'(en16), 32'h2);
    wait_idle16("s4_idle", 2000);
    repeat (100) @(negedge clk);
    check_eq("s4_drain", 32'(q16.size()), 0);
`ifdef RO_SENSOR_CHECKSUM_EN
    check_eq("s4_nbytes", 32'(txcnt16 - tx_before), 5);
`else
    check_eq("s4_nbytes", 32'(txcnt16 - tx_before), 4);
`endif

    // reset mid-GATE
    per = '{10, 0, 0, 0};
    cmd16(8'h30);
    repeat (60) @(negedge clk);
    check_eq("s5_roen", 32'(en16), 32'h1);
    tx_before = txcnt16;
    pulse_reset();
    repeat (600) @(negedge clk);
    check_eq("s5_silent", 32'(txcnt16 - tx_before), 0);
    check_eq("s5_busy", 32'(busy16), 0);

    // reset between bytes with tx_busy held high
    per = '{0, 0, 10, 0};
    q16.push_back(8'hA5);
    cmd16(8'h32);
    n = 0;
    while (q16.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    check_eq("s6_hdr", 32'(q16.size()), 0);
    hold16 = 1'b1;
    repeat (5) @(negedge clk);
    tx_before = txcnt16;
    pulse_reset();
    hold16 = 1'b0;
    repeat (200) @(negedge clk);
    check_eq("s6_silent", 32'(txcnt16 - tx_before), 0);
    check_eq("s6_busy", 32'(busy16), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
